// File: rtl/rmii_rx_framer.sv
// RMII receive framer: hunts preamble/SFD, then strobes payload dibits with byte/frame markers.
// One clock from rxd_in sample to data_out/trigger; no backpressure, since the PHY stream cannot be stalled.
module rmii_rx_framer #(
  parameter int MIN_PREAMBLE = 8,
  parameter int MAX_BYTES    = 1522,
  parameter int COUNT_WIDTH  = 11
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   crs_dv_in,
  input  logic [1:0]             rxd_in,
  output logic [1:0]             data_out,
  output logic                   trigger,
  output logic                   byte_done,
  output logic                   frame_start,
  output logic                   frame_end,
  output logic                   frame_err,
  output logic [COUNT_WIDTH-1:0] byte_count_out
);

  localparam int PRE_W = $clog2(MIN_PREAMBLE + 2);
  localparam logic [PRE_W-1:0]       PRE_MIN = PRE_W'(MIN_PREAMBLE);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = COUNT_WIDTH'(MAX_BYTES);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DISCARD} state_t;

  state_t                   state, state_nxt;
  logic [PRE_W-1:0]         pre_cnt, pre_cnt_nxt;
  logic [1:0]               dibit_cnt, dibit_cnt_nxt;
  logic [1:0]               data_nxt;
  logic                     trigger_nxt, byte_done_nxt;
  logic                     frame_start_nxt, frame_end_nxt, frame_err_nxt;
  logic [COUNT_WIDTH-1:0]   byte_cnt_nxt;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      pre_cnt        <= '0;
      dibit_cnt      <= '0;
      data_out       <= '0;
      trigger        <= 1'b0;
      byte_done      <= 1'b0;
      frame_start    <= 1'b0;
      frame_end      <= 1'b0;
      frame_err      <= 1'b0;
      byte_count_out <= '0;
    end else begin
      state          <= state_nxt;
      pre_cnt        <= pre_cnt_nxt;
      dibit_cnt      <= dibit_cnt_nxt;
      data_out       <= data_nxt;
      trigger        <= trigger_nxt;
      byte_done      <= byte_done_nxt;
      frame_start    <= frame_start_nxt;
      frame_end      <= frame_end_nxt;
      frame_err      <= frame_err_nxt;
      byte_count_out <= byte_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (crs_dv_in && rxd_in == 2'b01) state_nxt = PREAMBLE;
      PREAMBLE:
        if (!crs_dv_in) state_nxt = IDLE;
        else if (rxd_in == 2'b11) state_nxt = (pre_cnt >= PRE_MIN) ? DATA : IDLE;
        else if (rxd_in != 2'b01) state_nxt = IDLE;
      DATA:
        // A full-size frame that still has carrier on the next sample is oversize.
        if (!crs_dv_in) state_nxt = IDLE;
        else if (byte_count_out == CNT_MAX) state_nxt = DISCARD;
      DISCARD:
        if (!crs_dv_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pre_cnt_nxt     = pre_cnt;
    dibit_cnt_nxt   = dibit_cnt;
    data_nxt        = data_out;
    trigger_nxt     = 1'b0;
    byte_done_nxt   = 1'b0;
    frame_start_nxt = 1'b0;
    frame_end_nxt   = 1'b0;
    frame_err_nxt   = 1'b0;
    byte_cnt_nxt    = byte_count_out;
    case (state)
      IDLE:
        if (crs_dv_in && rxd_in == 2'b01) pre_cnt_nxt = PRE_W'(1);
      PREAMBLE:
        if (crs_dv_in && rxd_in == 2'b01 && pre_cnt < PRE_MIN) begin
          pre_cnt_nxt = pre_cnt + PRE_W'(1);
        end else if (crs_dv_in && rxd_in == 2'b11 && pre_cnt >= PRE_MIN) begin
          frame_start_nxt = 1'b1;
          byte_cnt_nxt    = '0;
          dibit_cnt_nxt   = '0;
        end
      DATA:
        if (!crs_dv_in) begin
          frame_end_nxt = 1'b1;
          frame_err_nxt = (dibit_cnt != 2'd0) || (byte_count_out == '0);
        end else if (byte_count_out != CNT_MAX) begin
          data_nxt      = rxd_in;
          trigger_nxt   = 1'b1;
          dibit_cnt_nxt = dibit_cnt + 2'd1;
          if (dibit_cnt == 2'd3) begin
            byte_done_nxt = 1'b1;
            byte_cnt_nxt  = byte_count_out + COUNT_WIDTH'(1);
          end
        end
      DISCARD:
        if (!crs_dv_in) begin
          frame_end_nxt = 1'b1;
          frame_err_nxt = 1'b1;
        end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Directed bench for rmii_rx_framer: default instance plus a MAX_BYTES=4 instance on the same RMII inputs.
module tb_rmii_rx_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        crs_dv = 1'b1;
  logic [1:0]  rxd = 2'b01;

  logic [1:0]  data_out;
  logic        trigger, byte_done, frame_start, frame_end, frame_err;
  logic [10:0] byte_count;
  logic [1:0]  s_data_out;
  logic        s_trigger, s_byte_done, s_frame_start, s_frame_end, s_frame_err;
  logic [10:0] s_byte_count;

  int passed = 0;
  int total  = 0;

  int trig_cnt, bd_cnt, bd_idx, fs_cnt, fe_cnt, fe_err, fe_count, overlap;
  int s_trig_cnt, s_fe_cnt, s_fe_err, s_fe_count;
  logic [1:0] data_q[$];

  always #10 clk = ~clk;

  rmii_rx_framer dut (
    .clk_in(clk), .rst_in(rst_n), .crs_dv_in(crs_dv), .rxd_in(rxd),
    .data_out(data_out), .trigger(trigger), .byte_done(byte_done),
    .frame_start(frame_start), .frame_end(frame_end), .frame_err(frame_err),
    .byte_count_out(byte_count)
  );

  rmii_rx_framer #(.MAX_BYTES(4)) dut_small (
    .clk_in(clk), .rst_in(rst_n), .crs_dv_in(crs_dv), .rxd_in(rxd),
    .data_out(s_data_out), .trigger(s_trigger), .byte_done(s_byte_done),
    .frame_start(s_frame_start), .frame_end(s_frame_end), .frame_err(s_frame_err),
    .byte_count_out(s_byte_count)
  );

  // Event monitor: outputs are registered, so sampling on the falling edge is stable.
  always @(negedge clk) begin
    if (rst_n) begin
      if (trigger) begin trig_cnt++; data_q.push_back(data_out); end
      if (byte_done) begin bd_cnt++; bd_idx = trig_cnt; end
      if (frame_start) fs_cnt++;
      if (frame_end) begin
        fe_cnt++; fe_err = int'(frame_err); fe_count = int'(byte_count);
        if (trigger) overlap++;
      end
      if (s_trigger) s_trig_cnt++;
      if (s_frame_end) begin s_fe_cnt++; s_fe_err = int'(s_frame_err); s_fe_count = int'(s_byte_count); end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic clr();
    trig_cnt = 0; bd_cnt = 0; bd_idx = 0; fs_cnt = 0; fe_cnt = 0; fe_err = -1; fe_count = -1;
    overlap = 0; s_trig_cnt = 0; s_fe_cnt = 0; s_fe_err = -1; s_fe_count = -1;
    data_q.delete();
  endtask

  task automatic drv(input logic c, input logic [1:0] d);
    @(negedge clk); crs_dv = c; rxd = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 2'b00);
  endtask

  task automatic preamble_sfd(input int n);
    for (int i = 0; i < n; i++) drv(1'b1, 2'b01);
    drv(1'b1, 2'b11);
  endtask

  task automatic send_byte(input logic [7:0] b);
    drv(1'b1, b[1:0]); drv(1'b1, b[3:2]); drv(1'b1, b[5:4]); drv(1'b1, b[7:6]);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (data_out !== 2'b00) $display("FAIL reset_data: got %b want 00", data_out); else passed++;
    total++; if ({trigger, byte_done, frame_start, frame_end, frame_err} !== 5'b0)
      $display("FAIL reset_strobes: got %b want 00000", {trigger, byte_done, frame_start, frame_end, frame_err});
    else passed++;
    total++; if (byte_count !== 11'd0) $display("FAIL reset_count: got %0d want 0", byte_count); else passed++;
    clr();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    drv(1'b1, 2'b11);
    idle(2);
    total++; if (fs_cnt !== 0 || trig_cnt !== 0)
      $display("FAIL reset_release: frame_start=%0d triggers=%0d want 0/0", fs_cnt, trig_cnt);
    else passed++;
  endtask

  task automatic test_basic();
    logic [1:0] exp_d[4] = '{2'b01, 2'b01, 2'b10, 2'b10};
    clr();
    preamble_sfd(8);
    total++; if (frame_start !== 1'b1 || trigger !== 1'b0)
      $display("FAIL basic_frame_start: frame_start=%b trigger=%b want 1/0", frame_start, trigger);
    else passed++;
    send_byte(8'hA5);
    drv(1'b0, 2'b00);
    total++; if (frame_end !== 1'b1 || frame_err !== 1'b0 || byte_count !== 11'd1 || trigger !== 1'b0)
      $display("FAIL basic_end: end=%b err=%b count=%0d trig=%b want 1/0/1/0", frame_end, frame_err, byte_count, trigger);
    else passed++;
    idle(2);
    total++; if (trig_cnt !== 4 || bd_cnt !== 1 || bd_idx !== 4 || fs_cnt !== 1 || fe_cnt !== 1)
      $display("FAIL basic_counts: trig=%0d bd=%0d bd_at=%0d fs=%0d fe=%0d want 4/1/4/1/1", trig_cnt, bd_cnt, bd_idx, fs_cnt, fe_cnt);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (data_q.size() <= i || data_q[i] !== exp_d[i])
        $display("FAIL basic_dibit%0d: got %b want %b", i, (data_q.size() > i) ? data_q[i] : 2'bxx, exp_d[i]);
      else passed++;
    end
    total++; if (byte_count !== 11'd1 || data_out !== 2'b10)
      $display("FAIL basic_hold: count=%0d data=%b want 1/10", byte_count, data_out);
    else passed++;
  endtask

  task automatic test_short_preamble();
    logic [1:0] exp_d[4] = '{2'b00, 2'b11, 2'b11, 2'b00};
    clr();
    preamble_sfd(3);
    total++; if (fs_cnt !== 0 || trig_cnt !== 0 || frame_start !== 1'b0)
      $display("FAIL short_pre_reject: fs=%0d trig=%0d want 0/0", fs_cnt, trig_cnt);
    else passed++;
    preamble_sfd(8);
    send_byte(8'h3C);
    drv(1'b0, 2'b00);
    idle(2);
    total++; if (fs_cnt !== 1 || trig_cnt !== 4 || fe_err !== 0 || fe_count !== 1)
      $display("FAIL short_pre_next: fs=%0d trig=%0d err=%0d count=%0d want 1/4/0/1", fs_cnt, trig_cnt, fe_err, fe_count);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (data_q.size() <= i || data_q[i] !== exp_d[i])
        $display("FAIL short_pre_dibit%0d: got %b want %b", i, (data_q.size() > i) ? data_q[i] : 2'bxx, exp_d[i]);
      else passed++;
    end
  endtask

  task automatic test_partial();
    logic [1:0] d[6] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10};
    clr();
    preamble_sfd(8);
    for (int i = 0; i < 6; i++) drv(1'b1, d[i]);
    drv(1'b0, 2'b00);
    idle(2);
    total++; if (trig_cnt !== 6 || bd_cnt !== 1 || fe_cnt !== 1 || fe_err !== 1 || fe_count !== 1)
      $display("FAIL partial: trig=%0d bd=%0d fe=%0d err=%0d count=%0d want 6/1/1/1/1", trig_cnt, bd_cnt, fe_cnt, fe_err, fe_count);
    else passed++;
  endtask

  task automatic test_empty();
    clr();
    preamble_sfd(10);
    drv(1'b0, 2'b00);
    idle(2);
    total++; if (trig_cnt !== 0 || fe_cnt !== 1 || fe_err !== 1 || fe_count !== 0)
      $display("FAIL empty: trig=%0d fe=%0d err=%0d count=%0d want 0/1/1/0", trig_cnt, fe_cnt, fe_err, fe_count);
    else passed++;
  endtask

  task automatic test_max_exact();
    clr();
    preamble_sfd(8);
    for (int i = 0; i < 4; i++) send_byte(8'h96);
    drv(1'b0, 2'b00);
    idle(2);
    total++; if (s_trig_cnt !== 16 || s_fe_cnt !== 1 || s_fe_err !== 0 || s_fe_count !== 4)
      $display("FAIL max_exact: trig=%0d fe=%0d err=%0d count=%0d want 16/1/0/4", s_trig_cnt, s_fe_cnt, s_fe_err, s_fe_count);
    else passed++;
  endtask

  task automatic test_oversize();
    clr();
    preamble_sfd(8);
    for (int i = 0; i < 6; i++) send_byte(8'h5A);
    total++; if (s_frame_end !== 1'b0 || s_byte_count !== 11'd4)
      $display("FAIL oversize_discard: end=%b count=%0d want 0/4", s_frame_end, s_byte_count);
    else passed++;
    drv(1'b0, 2'b00);
    total++; if (s_frame_end !== 1'b1 || s_frame_err !== 1'b1 || s_trigger !== 1'b0)
      $display("FAIL oversize_end: end=%b err=%b trig=%b want 1/1/0", s_frame_end, s_frame_err, s_trigger);
    else passed++;
    idle(2);
    total++; if (s_trig_cnt !== 16 || s_fe_cnt !== 1 || s_byte_count !== 11'd4)
      $display("FAIL oversize_counts: trig=%0d fe=%0d count=%0d want 16/1/4", s_trig_cnt, s_fe_cnt, s_byte_count);
    else passed++;
    total++; if (trig_cnt !== 24 || fe_err !== 0 || fe_count !== 6)
      $display("FAIL oversize_big_dut: trig=%0d err=%0d count=%0d want 24/0/6", trig_cnt, fe_err, fe_count);
    else passed++;
  endtask

  task automatic test_false_carrier();
    clr();
    for (int i = 0; i < 10; i++) drv(1'b1, 2'b00);
    preamble_sfd(8);
    send_byte(8'hC3);
    send_byte(8'h0F);
    drv(1'b0, 2'b00);
    idle(2);
    total++; if (trig_cnt !== 8 || fs_cnt !== 1 || bd_cnt !== 2 || fe_err !== 0 || fe_count !== 2)
      $display("FAIL false_carrier: trig=%0d fs=%0d bd=%0d err=%0d count=%0d want 8/1/2/0/2", trig_cnt, fs_cnt, bd_cnt, fe_err, fe_count);
    else passed++;
  endtask

  task automatic test_back_to_back();
    clr();
    preamble_sfd(8);
    send_byte(8'h12);
    drv(1'b0, 2'b00);
    preamble_sfd(8);
    send_byte(8'h34);
    send_byte(8'h56);
    drv(1'b0, 2'b00);
    idle(2);
    total++; if (fs_cnt !== 2 || fe_cnt !== 2 || trig_cnt !== 12 || overlap !== 0 || fe_err !== 0 || fe_count !== 2)
      $display("FAIL back_to_back: fs=%0d fe=%0d trig=%0d overlap=%0d err=%0d count=%0d want 2/2/12/0/0/2",
               fs_cnt, fe_cnt, trig_cnt, overlap, fe_err, fe_count);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    clr();
    preamble_sfd(8);
    send_byte(8'hA5);
    drv(1'b1, 2'b11);
    @(negedge clk); crs_dv = 1'b0; rxd = 2'b00; rst_n = 1'b0;
    #1;
    total++; if (data_out !== 2'b00 || trigger !== 1'b0 || byte_count !== 11'd0)
      $display("FAIL reset_mid: data=%b trig=%b count=%0d want 00/0/0", data_out, trigger, byte_count);
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    idle(3);
    total++; if (fe_cnt !== 0 || frame_end !== 1'b0)
      $display("FAIL reset_mid_no_end: frame_end count=%0d want 0", fe_cnt);
    else passed++;
  endtask

  initial begin
    clr();
    test_reset();
    test_basic();
    test_short_preamble();
    test_partial();
    test_empty();
    test_max_exact();
    test_oversize();
    test_false_carrier();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
